multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle FSM successor to the single-cycle decoder. Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK
//  for RV32I subset: R-type ADD/SUB/AND/OR/XOR/SLT, ADDI/ANDI/ORI/XORI, LW, SW, BEQ.
//  Drives datapath muxes, a shared instruction/data memory handshake, illegal-op and bus-timeout traps,
//  and a retired-instruction counter. Sits between the IR/regfile/ALU datapath and the memory port.
// PARAMETERS
//  ALU_CTRL_W   3    alu_ctrl width; must be >= 3; upper bits zero-filled
//  MEM_TIMEOUT  16   max cycles waiting for mem_ready before bus-error trap; 0 = timeout disabled
//  RET_CNT_W    32   width of retired-instruction counter
// PORTS
//  clk          in   1            clock, all state on rising edge
//  rst          in   1            synchronous, active-high reset
//  instr        in   32           current IR contents (opcode [6:0], rd [11:7], funct3 [14:12], funct7 [31:25])
//  mem_ready    in   1            memory completes current request this cycle
//  alu_zero     in   1            ALU result == 0
//  mem_req      out  1            memory request valid
//  mem_we       out  1            1 = store, 0 = read
//  mem_addr_sel out  1            0 = PC, 1 = ALU result
//  ir_write     out  1            latch memory read data into IR
//  pc_write     out  1            update PC
//  pc_src       out  1            0 = ALU result (PC+4), 1 = branch target
//  alu_src_a    out  1            0 = PC, 1 = rs1
//  alu_src_b    out  2            00 = rs2, 01 = immediate, 10 = constant 4
//  alu_ctrl     out  ALU_CTRL_W   ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5
//  wb_sel       out  1            0 = ALU result, 1 = memory data
//  reg_write    out  1            write rd
//  retire       out  1            one-cycle pulse per completed instruction
//  ret_count    out  RET_CNT_W    retired-instruction count, wraps to 0
//  illegal      out  1            sticky: unsupported opcode/funct decoded
//  bus_error    out  1            sticky: memory timeout
//  state        out  3            FETCH=0 DECODE=1 EXECUTE=2 MEM=3 WB=4 TRAP=7
// BEHAVIOUR
//  Reset: while rst=1 every output is 0 (state=FETCH, ret_count=0, traps cleared). rst overrides any state,
//   including mid-MEM wait; in-flight request is abandoned and no retire is issued.
//  FETCH: mem_req=1, mem_addr_sel=0, alu_src_a=0, alu_src_b=10, alu_ctrl=ADD. Waits for mem_ready;
//   in the mem_ready cycle ir_write=1, pc_write=1, pc_src=0 -> DECODE. Minimum 1 cycle.
//  DECODE: one cycle. Unsupported opcode or funct combination -> TRAP with illegal=1; otherwise -> EXECUTE.
//  EXECUTE (one cycle): alu_src_a=1.
//   R-type: alu_src_b=00, alu_ctrl from {funct7,funct3} -> WB.
//   I-ALU/LW/SW: alu_src_b=01; alu_ctrl from funct3 (LW/SW: ADD) -> WB (I-ALU) or MEM (LW/SW).
//   BEQ: alu_src_b=00, alu_ctrl=SUB. If alu_zero: pc_write=1, pc_src=1. Retire; -> FETCH.
//  MEM: mem_req=1, mem_addr_sel=1, mem_we=(SW). Waits for mem_ready. SW: retire -> FETCH. LW: -> WB.
//  WB (one cycle): reg_write=1 unless rd==0 (reg_write=0, still retires); wb_sel=1 for LW, 0 otherwise.
//   Retire -> FETCH.
//  Outputs not listed for a state are 0. Control signals decode combinationally from state, instr, and
//   mem_ready/alu_zero; state and counters are registered.
//  Latency (zero-wait memory): R/I 4 cycles, LW 5, SW 4, BEQ 3.
//  Timeout: wait counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 and mem_ready=0.
//   Reaching MEM_TIMEOUT -> TRAP, bus_error=1. mem_ready in the same cycle as the limit wins (no trap).
//  TRAP: all control outputs 0 and mem_req=0. Only rst exits.
//  retire pulses in the same cycle as the final control action. ret_count increments on the next edge,
//   wrapping from all-ones to 0.
// TESTING
//  ADD x3,x1,x2 (0x002081B3), mem_ready=1 always -> states 0,1,2,4; alu_ctrl=0; reg_write=1 in WB; ret_count=1.
//  LW x5,8(x1), data-phase mem_ready held low 3 cycles -> MEM lasts 4 cycles, mem_we=0, WB with wb_sel=1.
//  BEQ with alu_zero=1, then alu_zero=0 -> pc_write+pc_src=1 only in the first case; both retire in 3 cycles.
//  Opcode 0x7F -> TRAP after DECODE, illegal=1, mem_req stays 0 until rst; rst -> FETCH, illegal=0.
//  MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP after 4 cycles, bus_error=1, no retire.
//  RET_CNT_W=2, retire 5 ADDI -> ret_count 1,2,3,0,1. rst asserted mid-MEM -> all outputs 0 next cycle.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RV32I-subset control FSM with memory handshake, traps and retire counter
module multicycle_control_unit #(
   parameter int ALU_CTRL_W  = 3,
   parameter int MEM_TIMEOUT = 16,
   parameter int RET_CNT_W   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           instr,
   input  logic                  mem_ready,
   input  logic                  alu_zero,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic                  mem_addr_sel,
   output logic                  ir_write,
   output logic                  pc_write,
   output logic                  pc_src,
   output logic                  alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [ALU_CTRL_W-1:0] alu_ctrl,
   output logic                  wb_sel,
   output logic                  reg_write,
   output logic                  retire,
   output logic [RET_CNT_W-1:0]  ret_count,
   output logic                  illegal,
   output logic                  bus_error,
   output logic [2:0]            state
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_TRAP    = 3'd7
   } state_t;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SLT = 3'd5;

   // Wait counter only needs to reach MEM_TIMEOUT-1; keep at least one bit when timeout is 0 or 1.
   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

   state_t                state_q, state_d;
   logic [WAIT_W-1:0]     wait_q;
   logic [RET_CNT_W-1:0]  ret_q;
   logic                  illegal_q, bus_error_q;

   logic       is_r, is_i, is_lw, is_sw, is_beq, legal;
   logic [2:0] dec_ctrl;

   logic       req_c, we_c, addr_sel_c, ir_write_c, pc_write_c, pc_src_c, src_a_c;
   logic [1:0] src_b_c;
   logic [2:0] ctrl_c;
   logic       wb_sel_c, reg_write_c, retire_c, set_illegal, set_bus_error;
   logic       timeout_hit;

   // Instruction class and ALU operation decode from the IR fields.
   always_comb begin
      is_r     = 1'b0;
      is_i     = 1'b0;
      is_lw    = 1'b0;
      is_sw    = 1'b0;
      is_beq   = 1'b0;
      legal    = 1'b0;
      dec_ctrl = OP_ADD;
      case (instr[6:0])
         7'h33: begin
            is_r = 1'b1;
            if (instr[31:25] == 7'h00) begin
               legal = 1'b1;
               case (instr[14:12])
                  3'b000:  dec_ctrl = OP_ADD;
                  3'b111:  dec_ctrl = OP_AND;
                  3'b110:  dec_ctrl = OP_OR;
                  3'b100:  dec_ctrl = OP_XOR;
                  3'b010:  dec_ctrl = OP_SLT;
                  default: legal = 1'b0;
               endcase
            end else if (instr[31:25] == 7'h20 && instr[14:12] == 3'b000) begin
               legal    = 1'b1;
               dec_ctrl = OP_SUB;
            end
         end
         7'h13: begin
            is_i  = 1'b1;
            legal = 1'b1;
            case (instr[14:12])
               3'b000:  dec_ctrl = OP_ADD;
               3'b111:  dec_ctrl = OP_AND;
               3'b110:  dec_ctrl = OP_OR;
               3'b100:  dec_ctrl = OP_XOR;
               default: legal = 1'b0;
            endcase
         end
         7'h03: begin
            is_lw = 1'b1;
            legal = (instr[14:12] == 3'b010);
         end
         7'h23: begin
            is_sw = 1'b1;
            legal = (instr[14:12] == 3'b010);
         end
         7'h63: begin
            is_beq = 1'b1;
            legal  = (instr[14:12] == 3'b000);
         end
         default: legal = 1'b0;
      endcase
   end

   // The limit cycle only traps when mem_ready is still low; callers check mem_ready first.
   assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LIMIT);

   // Next-state and per-state control decode.
   always_comb begin
      state_d       = state_q;
      req_c         = 1'b0;
      we_c          = 1'b0;
      addr_sel_c    = 1'b0;
      ir_write_c    = 1'b0;
      pc_write_c    = 1'b0;
      pc_src_c      = 1'b0;
      src_a_c       = 1'b0;
      src_b_c       = 2'b00;
      ctrl_c        = OP_ADD;
      wb_sel_c      = 1'b0;
      reg_write_c   = 1'b0;
      retire_c      = 1'b0;
      set_illegal   = 1'b0;
      set_bus_error = 1'b0;
      case (state_q)
         S_FETCH: begin
            req_c   = 1'b1;
            src_b_c = 2'b10;
            if (mem_ready) begin
               ir_write_c = 1'b1;
               pc_write_c = 1'b1;
               state_d    = S_DECODE;
            end else if (timeout_hit) begin
               set_bus_error = 1'b1;
               state_d       = S_TRAP;
            end
         end
         S_DECODE: begin
            if (legal) begin
               state_d = S_EXECUTE;
            end else begin
               set_illegal = 1'b1;
               state_d     = S_TRAP;
            end
         end
         S_EXECUTE: begin
            src_a_c = 1'b1;
            if (is_r) begin
               ctrl_c  = dec_ctrl;
               state_d = S_WB;
            end else if (is_i) begin
               src_b_c = 2'b01;
               ctrl_c  = dec_ctrl;
               state_d = S_WB;
            end else if (is_lw || is_sw) begin
               src_b_c = 2'b01;
               state_d = S_MEM;
            end else if (is_beq) begin
               ctrl_c     = OP_SUB;
               pc_write_c = alu_zero;
               pc_src_c   = alu_zero;
               retire_c   = 1'b1;
               state_d    = S_FETCH;
            end else begin
               // IR changed under us after a legal decode; treat as illegal rather than guess.
               set_illegal = 1'b1;
               state_d     = S_TRAP;
            end
         end
         S_MEM: begin
            req_c      = 1'b1;
            addr_sel_c = 1'b1;
            we_c       = is_sw;
            if (mem_ready) begin
               if (is_sw) begin
                  retire_c = 1'b1;
                  state_d  = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (timeout_hit) begin
               set_bus_error = 1'b1;
               state_d       = S_TRAP;
            end
         end
         S_WB: begin
            reg_write_c = (instr[11:7] != 5'd0);
            wb_sel_c    = is_lw;
            retire_c    = 1'b1;
            state_d     = S_FETCH;
         end
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
   end

   // State, wait counter, retire counter and sticky trap flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_FETCH;
         wait_q      <= '0;
         ret_q       <= '0;
         illegal_q   <= 1'b0;
         bus_error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= (req_c && !mem_ready) ? wait_q + WAIT_W'(1) : '0;
         if (retire_c)      ret_q       <= ret_q + RET_CNT_W'(1);
         if (set_illegal)   illegal_q   <= 1'b1;
         if (set_bus_error) bus_error_q <= 1'b1;
      end
   end

   // Hold every output at zero while reset is asserted, even before the reset edge.
   always_comb begin
      mem_req      = !rst && req_c;
      mem_we       = !rst && we_c;
      mem_addr_sel = !rst && addr_sel_c;
      ir_write     = !rst && ir_write_c;
      pc_write     = !rst && pc_write_c;
      pc_src       = !rst && pc_src_c;
      alu_src_a    = !rst && src_a_c;
      alu_src_b    = rst ? 2'b00 : src_b_c;
      alu_ctrl     = rst ? '0 : ALU_CTRL_W'(ctrl_c);
      wb_sel       = !rst && wb_sel_c;
      reg_write    = !rst && reg_write_c;
      retire       = !rst && retire_c;
      ret_count    = rst ? '0 : ret_q;
      illegal      = !rst && illegal_q;
      bus_error    = !rst && bus_error_q;
      state        = rst ? 3'd0 : state_q;
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        mem_ready;
   logic        alu_zero;
   logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src_a;
   logic [1:0]  alu_src_b;
   logic [2:0]  alu_ctrl;
   logic        wb_sel, reg_write, retire, illegal, bus_error;
   logic [1:0]  ret_count;
   logic [2:0]  state;
   logic [21:0] all_out;

   int checks = 0;
   int errors = 0;
   int exp_ret = 0;

   multicycle_control_unit #(
      .ALU_CTRL_W (3),
      .MEM_TIMEOUT(4),
      .RET_CNT_W  (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .instr       (instr),
      .mem_ready   (mem_ready),
      .alu_zero    (alu_zero),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr_sel(mem_addr_sel),
      .ir_write    (ir_write),
      .pc_write    (pc_write),
      .pc_src      (pc_src),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .alu_ctrl    (alu_ctrl),
      .wb_sel      (wb_sel),
      .reg_write   (reg_write),
      .retire      (retire),
      .ret_count   (ret_count),
      .illegal     (illegal),
      .bus_error   (bus_error),
      .state       (state)
   );

   assign all_out = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src_a,
                     alu_src_b, alu_ctrl, wb_sel, reg_write, retire, illegal, bus_error,
                     state, ret_count};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_ret = 0;
      #1;
   endtask

   // One R-type or I-ALU instruction with zero-wait memory: FETCH, DECODE, EXECUTE, WB.
   task automatic run_alu(input string tag, input logic [31:0] ins, input logic [2:0] ctrl,
                          input logic [1:0] bsrc, input logic regw);
      instr = ins;
      mem_ready = 1'b1;
      #1;
      chk({tag, "_fetch"}, state, 0);
      tick();
      chk({tag, "_decode"}, state, 1);
      tick();
      chk({tag, "_exec"}, state, 2);
      chk({tag, "_ctrl"}, alu_ctrl, ctrl);
      chk({tag, "_srcb"}, alu_src_b, bsrc);
      chk({tag, "_srca"}, alu_src_a, 1);
      tick();
      chk({tag, "_wb"}, state, 4);
      chk({tag, "_regw"}, reg_write, regw);
      chk({tag, "_wbsel"}, wb_sel, 0);
      chk({tag, "_retire"}, retire, 1);
      exp_ret = (exp_ret + 1) % 4;
      tick();
      chk({tag, "_retcnt"}, ret_count, exp_ret);
   endtask

   initial begin
      rst = 1'b1;
      instr = 32'h0;
      mem_ready = 1'b1;
      alu_zero = 1'b0;
      tick();
      tick();
      chk("reset_outputs", all_out, 0);

      // First FETCH after reset release
      rst = 1'b0;
      instr = 32'h002081B3;
      #1;
      chk("fetch_req", mem_req, 1);
      chk("fetch_srcb", alu_src_b, 2'b10);
      chk("fetch_irw", ir_write, 1);
      chk("fetch_pcw", pc_write, 1);
      chk("fetch_pcsrc", pc_src, 0);
      chk("fetch_addr", mem_addr_sel, 0);

      run_alu("add",  32'h002081B3, 3'd0, 2'b00, 1'b1);
      run_alu("sub",  32'h402081B3, 3'd1, 2'b00, 1'b1);
      run_alu("slt",  32'h0020A1B3, 3'd5, 2'b00, 1'b1);
      run_alu("and",  32'h0020F1B3, 3'd2, 2'b00, 1'b1);
      run_alu("ori",  32'h0010E093, 3'd3, 2'b01, 1'b1);
      run_alu("xori", 32'h0010C093, 3'd4, 2'b01, 1'b1);
      run_alu("addi_x0", 32'h00100013, 3'd0, 2'b01, 1'b0);

      // LW x5,8(x1) with three data-phase wait cycles
      instr = 32'h0080A283;
      mem_ready = 1'b1;
      tick();
      tick();
      chk("lw_exec_srcb", alu_src_b, 2'b01);
      chk("lw_exec_ctrl", alu_ctrl, 0);
      tick();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("lw_mem_wait_state", state, 3);
         chk("lw_mem_wait_req", {mem_req, mem_addr_sel, mem_we}, 3'b110);
         tick();
      end
      mem_ready = 1'b1;
      #1;
      chk("lw_mem_last", state, 3);
      chk("lw_mem_noretire", retire, 0);
      tick();
      chk("lw_wb", state, 4);
      chk("lw_wbsel", wb_sel, 1);
      chk("lw_regw", reg_write, 1);
      chk("lw_retire", retire, 1);
      exp_ret = (exp_ret + 1) % 4;
      tick();
      chk("lw_retcnt", ret_count, exp_ret);

      // BEQ taken then not taken
      for (int k = 0; k < 2; k++) begin
         instr = 32'h00208063;
         alu_zero = (k == 0);
         tick();
         tick();
         chk("beq_exec", state, 2);
         chk("beq_ctrl", alu_ctrl, 1);
         chk("beq_srcb", alu_src_b, 0);
         chk("beq_pc", {pc_write, pc_src}, (k == 0) ? 2'b11 : 2'b00);
         chk("beq_retire", retire, 1);
         exp_ret = (exp_ret + 1) % 4;
         tick();
         chk("beq_fetch", state, 0);
         chk("beq_retcnt", ret_count, exp_ret);
      end
      alu_zero = 1'b0;

      // SW x2,4(x1)
      instr = 32'h0020A223;
      tick();
      tick();
      tick();
      chk("sw_mem", state, 3);
      chk("sw_we", {mem_req, mem_addr_sel, mem_we}, 3'b111);
      chk("sw_retire", retire, 1);
      exp_ret = (exp_ret + 1) % 4;
      tick();
      chk("sw_fetch", state, 0);
      chk("sw_retcnt", ret_count, exp_ret);

      // Illegal opcode 0x7F traps and holds until reset
      instr = 32'h0000007F;
      tick();
      chk("ill_decode", state, 1);
      tick();
      chk("ill_trap", state, 7);
      chk("ill_flag", illegal, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ill_hold", {state, mem_req, retire}, 5'b11100);
      end
      do_reset();
      chk("ill_reset_state", state, 0);
      chk("ill_reset_flag", illegal, 0);
      chk("ill_reset_cnt", ret_count, 0);

      // Illegal funct combination (funct7=0x20 with AND funct3)
      instr = 32'h4020F1B3;
      tick();
      tick();
      chk("illf_trap", {state, illegal}, 4'b1111);
      do_reset();

      // Fetch timeout with MEM_TIMEOUT=4
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("to_wait", {state, mem_req}, 4'b0001);
         tick();
      end
      chk("to_trap", state, 7);
      chk("to_buserr", bus_error, 1);
      chk("to_noretire", {retire, ret_count, mem_req}, 0);
      do_reset();
      chk("to_reset", bus_error, 0);

      // mem_ready arriving in the limit cycle wins over the timeout
      instr = 32'h002081B3;
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      mem_ready = 1'b1;
      #1;
      chk("lim_irw", ir_write, 1);
      tick();
      chk("lim_decode", state, 1);
      chk("lim_nobuserr", bus_error, 0);
      do_reset();

      // Reset asserted mid-MEM abandons the request
      instr = 32'h0080A283;
      mem_ready = 1'b1;
      tick();
      tick();
      tick();
      mem_ready = 1'b0;
      #1;
      chk("rm_mem", state, 3);
      tick();
      rst = 1'b1;
      #1;
      chk("rm_during_rst", all_out, 0);
      tick();
      chk("rm_after_edge", all_out, 0);
      rst = 1'b0;
      mem_ready = 1'b1;
      #1;
      chk("rm_release", {state, mem_req, ret_count}, 6'b000100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
